// File: rtl/hazard_pkg.sv
// ------------------------------------------------------------------
// hazard_pkg: shared types/constants for the pipeline hazard unit. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

package hazard_pkg;

  localparam logic [1:0] OPT_NONE  = 2'b00;
  localparam logic [1:0] OPT_ALU   = 2'b01;
  localparam logic [1:0] OPT_LOAD  = 2'b10;
  localparam logic [1:0] OPT_STORE = 2'b11;

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_EX_ALU  = 2'b01;
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;
  localparam logic [1:0] FWD_MEM_LD  = 2'b11;

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [1:0] optype;
    logic       fwd_store;
  } slot_t;

  localparam int SLOT_W = $bits(slot_t);

  // x0 is never a writer, so it can never be forwarded or stalled on.
  function automatic logic writes_reg(slot_t s, logic [4:0] rs, logic [1:0] opt);
    return s.valid && (s.rd != 5'd0) && (s.rd == rs) && (s.optype == opt);
  endfunction

  function automatic logic [1:0] fwd_sel(logic en, logic [4:0] rs, slot_t ex, slot_t mem);
    logic [1:0] sel;
    sel = FWD_RF;
    if (en) begin
      if (writes_reg(ex, rs, OPT_ALU))        sel = FWD_EX_ALU;
      else if (writes_reg(mem, rs, OPT_ALU))  sel = FWD_MEM_ALU;
      else if (writes_reg(mem, rs, OPT_LOAD)) sel = FWD_MEM_LD;
    end
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/hazard_track_unit_slot.sv
// ------------------------------------------------------------------
// hazard_slot: one shadow pipeline slot with bubble insertion. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module hazard_slot
  import hazard_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              bubble_i,
  input  logic [SLOT_W-1:0] slot_i,
  output logic [SLOT_W-1:0] slot_o
);

  logic [SLOT_W-1:0] slot_q;
  logic [SLOT_W-1:0] slot_d;

  always_comb begin
    slot_d = slot_i;
    if (bubble_i) slot_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) slot_q <= '0;
    else        slot_q <= slot_d;
  end

  assign slot_o = slot_q;

endmodule

`default_nettype wire

// File: rtl/hazard_track_unit.sv
// ------------------------------------------------------------------
// hazard_track_unit: forwarding, load-use stall and redirect flush. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module hazard_track_unit
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid_ID,
  input  logic             rs1use_ID,
  input  logic             rs2use_ID,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic [4:0]       rd_ID,
  input  logic [1:0]       hazard_optype_ID,
  input  logic             Branch_ID,
  output logic [1:0]       forward_ctrl_A,
  output logic [1:0]       forward_ctrl_B,
  output logic             forward_ctrl_ls,
  output logic             stall_PC,
  output logic             stall_IFID,
  output logic             flush_IDEX,
  output logic             flush_IFID,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [SLOT_W-1:0] ex_vec, mem_vec, ex_in;
  slot_t             ex_slot, mem_slot;
  logic              id_valid, ex_load, rs1_hit, rs2_hit, is_store;
  logic              stall, fwd_store, redirect;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  assign ex_slot  = slot_t'(ex_vec);
  assign mem_slot = slot_t'(mem_vec);

  // Gating with rst_n keeps every output low while reset is held.
  assign id_valid = valid_ID & rst_n;
  assign is_store = (hazard_optype_ID == OPT_STORE);
  assign ex_load  = ex_slot.valid && (ex_slot.rd != 5'd0) && (ex_slot.optype == OPT_LOAD);
  assign rs1_hit  = rs1use_ID && (rs1_ID == ex_slot.rd);
  assign rs2_hit  = rs2use_ID && (rs2_ID == ex_slot.rd);

  // A store whose only dependence is rs2 on the load picks the data up later.
  assign stall     = id_valid && ex_load && (rs1_hit || (rs2_hit && !is_store));
  assign fwd_store = id_valid && ex_load && is_store && rs2_hit && !rs1_hit;
  assign redirect  = id_valid && Branch_ID && !stall;

  assign forward_ctrl_A  = id_valid ? fwd_sel(rs1use_ID, rs1_ID, ex_slot, mem_slot) : FWD_RF;
  assign forward_ctrl_B  = id_valid ? fwd_sel(rs2use_ID, rs2_ID, ex_slot, mem_slot) : FWD_RF;
  assign forward_ctrl_ls = ex_slot.valid && ex_slot.fwd_store;
  assign stall_PC        = stall;
  assign stall_IFID      = stall;
  assign flush_IDEX      = stall;
  assign flush_IFID      = redirect;

  assign ex_in = {1'b1, rd_ID, hazard_optype_ID, fwd_store};

  hazard_slot u_ex_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .bubble_i (stall || !valid_ID),
    .slot_i   (ex_in),
    .slot_o   (ex_vec)
  );

  hazard_slot u_mem_slot (
    .clk      (clk),
    .rst_n    (rst_n),
    .bubble_i (1'b0),
    .slot_i   (ex_vec),
    .slot_o   (mem_vec)
  );

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != '1))    stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (redirect && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_hazard_track_unit.sv
// ------------------------------------------------------------------
// tb_hazard_track_unit: scoreboard bench with a behavioural pipeline model. Rev 1.0
// ------------------------------------------------------------------
`default_nettype none

module tb_hazard_track_unit;

  localparam int CW = 4;
  localparam int CMAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          valid_ID = 1'b0, rs1use_ID = 1'b0, rs2use_ID = 1'b0, Branch_ID = 1'b0;
  logic [4:0]    rs1_ID = '0, rs2_ID = '0, rd_ID = '0;
  logic [1:0]    hazard_optype_ID = '0;
  logic [1:0]    fa, fb;
  logic          ls, spc, sif, fide, fif;
  logic [CW-1:0] sc, fc;

  hazard_track_unit #(.CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .valid_ID(valid_ID),
    .rs1use_ID(rs1use_ID), .rs2use_ID(rs2use_ID),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .rd_ID(rd_ID),
    .hazard_optype_ID(hazard_optype_ID), .Branch_ID(Branch_ID),
    .forward_ctrl_A(fa), .forward_ctrl_B(fb), .forward_ctrl_ls(ls),
    .stall_PC(spc), .stall_IFID(sif), .flush_IDEX(fide), .flush_IFID(fif),
    .stall_cnt(sc), .flush_cnt(fc)
  );

  always #5 clk = ~clk;

  typedef struct {bit v; int rd; int opt; bit fs;} rec_t;
  typedef struct {int fa; int fb; int ls; int st; int fl; int sc; int fc;} exp_t;

  rec_t pipe[$];          // pipe[0] = instruction now in EX, pipe[1] = in MEM
  exp_t sbq[$];
  int   scnt_m = 0, fcnt_m = 0;
  int   n_cmp = 0, n_bad = 0;

  function automatic bit produces(rec_t s, int r, int opt);
    return s.v && s.rd != 0 && s.rd == r && s.opt == opt;
  endfunction

  function automatic int src(bit en, int r);
    if (!en) return 0;
    if (produces(pipe[0], r, 1)) return 1;
    if (produces(pipe[1], r, 1)) return 2;
    if (produces(pipe[1], r, 2)) return 3;
    return 0;
  endfunction

  function automatic void clear_model();
    rec_t b;
    b = '{v: 0, rd: 0, opt: 0, fs: 0};
    pipe.delete();
    pipe.push_back(b);
    pipe.push_back(b);
    scnt_m = 0;
    fcnt_m = 0;
  endfunction

  // Issue one ID-stage cycle at posedge+1, record expectations, advance the model.
  task automatic issue(bit v, bit r1u, bit r2u, int a, int b, int d, int opt, bit br);
    exp_t x;
    rec_t n;
    bit   ld_ex, h1, h2, st, fs;
    valid_ID = v; rs1use_ID = r1u; rs2use_ID = r2u;
    rs1_ID = 5'(a); rs2_ID = 5'(b); rd_ID = 5'(d);
    hazard_optype_ID = 2'(opt); Branch_ID = br;
    ld_ex = pipe[0].v && pipe[0].rd != 0 && pipe[0].opt == 2;
    h1 = r1u && (a == pipe[0].rd);
    h2 = r2u && (b == pipe[0].rd);
    st = v && ld_ex && (h1 || (h2 && opt != 3));
    fs = v && ld_ex && opt == 3 && h2 && !h1;
    x.fa = v ? src(r1u, a) : 0;
    x.fb = v ? src(r2u, b) : 0;
    x.ls = (pipe[0].v && pipe[0].fs) ? 1 : 0;
    x.st = st ? 1 : 0;
    x.fl = (v && br && !st) ? 1 : 0;
    x.sc = scnt_m;
    x.fc = fcnt_m;
    sbq.push_back(x);
    @(posedge clk);
    #1;
    if (x.st == 1 && scnt_m < CMAX) scnt_m++;
    if (x.fl == 1 && fcnt_m < CMAX) fcnt_m++;
    if (st || !v) n = '{v: 0, rd: 0, opt: 0, fs: 0};
    else          n = '{v: 1, rd: d, opt: opt, fs: fs};
    void'(pipe.pop_back());
    pipe.push_front(n);
  endtask

  // Assert reset at posedge+1 while the ID inputs stay as they are.
  task automatic reset_cycle();
    exp_t z;
    rst_n = 1'b0;
    clear_model();
    z = '{fa: 0, fb: 0, ls: 0, st: 0, fl: 0, sc: 0, fc: 0};
    sbq.push_back(z);
    @(posedge clk);
    #1;
  endtask

  task automatic check(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      check("fwd_A", int'(fa), e.fa);
      check("fwd_B", int'(fb), e.fb);
      check("fwd_ls", int'(ls), e.ls);
      check("stall_PC", int'(spc), e.st);
      check("stall_IFID", int'(sif), e.st);
      check("flush_IDEX", int'(fide), e.st);
      check("flush_IFID", int'(fif), e.fl);
      check("stall_cnt", int'(sc), e.sc);
      check("flush_cnt", int'(fc), e.fc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clear_model();
    #6;
    reset_cycle();
    reset_cycle();
    rst_n = 1'b1;
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    // ALU result forwarded from EX, then from MEM
    issue(1, 1, 1, 1, 2, 5, 1, 0);
    issue(1, 1, 0, 5, 0, 8, 1, 0);
    issue(1, 1, 0, 5, 0, 9, 0, 0);
    // load-use: one stall, then MEM load data
    issue(1, 1, 0, 1, 0, 6, 2, 0);
    issue(1, 1, 1, 3, 6, 10, 1, 0);
    issue(1, 1, 1, 3, 6, 10, 1, 0);
    // store after load: no stall, store-data forward next cycle
    issue(1, 1, 0, 1, 0, 7, 2, 0);
    issue(1, 1, 1, 2, 7, 4, 3, 0);
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    // taken branch, then branch stalled behind a load
    issue(1, 1, 1, 1, 2, 0, 0, 1);
    issue(1, 1, 0, 1, 0, 6, 2, 0);
    issue(1, 1, 1, 6, 2, 0, 0, 1);
    issue(1, 1, 1, 6, 2, 0, 0, 1);
    // x0 never forwards or stalls
    issue(1, 1, 0, 0, 0, 0, 1, 0);
    issue(1, 1, 0, 0, 0, 4, 1, 0);
    issue(1, 1, 0, 1, 0, 0, 2, 0);
    issue(1, 1, 1, 0, 0, 4, 1, 0);
    // back-to-back writers: youngest wins
    issue(1, 1, 0, 1, 0, 3, 1, 0);
    issue(1, 1, 0, 1, 0, 3, 1, 0);
    issue(1, 1, 1, 3, 3, 4, 0, 0);
    // reset asserted in the middle of a stall
    issue(1, 1, 0, 1, 0, 6, 2, 0);
    issue(1, 1, 0, 6, 0, 11, 1, 1);
    reset_cycle();
    reset_cycle();
    rst_n = 1'b1;
    issue(0, 1, 1, 6, 6, 0, 2, 1);
    issue(0, 1, 1, 6, 6, 0, 2, 1);
    // random traffic on a small register set to provoke many hazards
    for (int i = 0; i < 500; i++) begin
      issue(($urandom % 8) != 0, $urandom % 2, $urandom % 2,
            $urandom % 4, $urandom % 4, $urandom % 4,
            $urandom % 4, ($urandom % 5) == 0);
    end
    issue(0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    check("scoreboard_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
